// File: rtl/alu_arbiter_if.sv
// Request/response channel between one ALU client and the arbiter.
// The client drives requests and takes results; the arbiter grants and returns them.
interface alu_arbiter_if #(
   parameter int WIDTH = 64
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [3:0]       op_ctrl;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic             resp_zero;
   logic             resp_illop;

   modport master (
      output req_valid, op_a, op_b, op_ctrl, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_zero, resp_illop
   );

   modport slave (
      input  req_valid, op_a, op_b, op_ctrl, resp_ready,
      output req_ready, resp_valid, resp_result, resp_zero, resp_illop
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// One transaction in flight: grant, drive the ALU for a cycle, hold the result until taken.
//
//  state | meaning
//  IDLE  | granting; ALU drive regs hold their last value
//  EXEC  | ALU driven from latched operands for one full cycle
//  RESP  | owner's response valid, waiting for owner resp_ready
module alu_arbiter #(
   parameter int WIDTH     = 64,
   parameter bit FIRST_PRI = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     r0,
   alu_arbiter_if.slave     r1,
   output logic [WIDTH-1:0] alu_in1,
   output logic [WIDTH-1:0] alu_in2,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] in1_q, in1_d;
   logic [WIDTH-1:0] in2_q, in2_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illop_q, illop_d;

   logic grant;
   logic any_valid;
   logic ready0, ready1;
   logic owner_resp_ready;

   function automatic logic is_legal(input logic [3:0] c);
      return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010) || (c == 4'b0110);
   endfunction

   // Under contention the requester that did not win last time is favoured.
   always_comb begin
      any_valid = r0.req_valid | r1.req_valid;
      if (r0.req_valid && r1.req_valid) begin
         grant = ~last_grant_q;
      end else if (r1.req_valid) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
   end

   assign owner_resp_ready = owner_q ? r1.resp_ready : r0.resp_ready;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      in1_d        = in1_q;
      in2_d        = in2_q;
      ctrl_d       = ctrl_q;
      result_d     = result_q;
      zero_d       = zero_q;
      illop_d      = illop_q;
      ready0       = 1'b0;
      ready1       = 1'b0;

      case (state_q)
         IDLE: begin
            ready0 = any_valid && (grant == 1'b0);
            ready1 = any_valid && (grant == 1'b1);
            if (any_valid) begin
               owner_d      = grant;
               last_grant_d = grant;
               in1_d        = grant ? r1.op_a    : r0.op_a;
               in2_d        = grant ? r1.op_b    : r0.op_b;
               ctrl_d       = grant ? r1.op_ctrl : r0.op_ctrl;
               state_d      = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_result;
            zero_d   = alu_zero;
            illop_d  = ~is_legal(ctrl_q);
            state_d  = RESP;
         end
         RESP: begin
            if (owner_resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= ~FIRST_PRI;
         in1_q        <= '0;
         in2_q        <= '0;
         ctrl_q       <= 4'b0000;
         result_q     <= '0;
         zero_q       <= 1'b0;
         illop_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         in1_q        <= in1_d;
         in2_q        <= in2_d;
         ctrl_q       <= ctrl_d;
         result_q     <= result_d;
         zero_q       <= zero_d;
         illop_q      <= illop_d;
      end
   end

   assign alu_in1  = in1_q;
   assign alu_in2  = in2_q;
   assign alu_ctrl = ctrl_q;
   assign busy     = (state_q != IDLE);

   assign r0.req_ready   = ready0;
   assign r1.req_ready   = ready1;
   assign r0.resp_valid  = (state_q == RESP) && (owner_q == 1'b0);
   assign r1.resp_valid  = (state_q == RESP) && (owner_q == 1'b1);

   // Response data is shared; only the owner's resp_valid qualifies it.
   assign r0.resp_result = result_q;
   assign r1.resp_result = result_q;
   assign r0.resp_zero   = zero_q;
   assign r1.resp_zero   = zero_q;
   assign r0.resp_illop  = illop_q;
   assign r1.resp_illop  = illop_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to its ALU port.
module tb_alu_arbiter;
   localparam int WIDTH = 64;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] alu_in1, alu_in2, alu_result;
   logic [3:0]       alu_ctrl;
   logic             alu_zero;
   logic             busy;

   int checks   = 0;
   int failures = 0;

   alu_arbiter_if #(.WIDTH(WIDTH)) r0_if ();
   alu_arbiter_if #(.WIDTH(WIDTH)) r1_if ();

   alu_arbiter #(.WIDTH(WIDTH), .FIRST_PRI(1'b0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .r0         (r0_if.slave),
      .r1         (r1_if.slave),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_ctrl   (alu_ctrl),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .busy       (busy)
   );

   // External ALU: illegal codes return 0.
   always_comb begin
      case (alu_ctrl)
         4'b0000: alu_result = alu_in1 & alu_in2;
         4'b0001: alu_result = alu_in1 | alu_in2;
         4'b0010: alu_result = alu_in1 + alu_in2;
         4'b0110: alu_result = alu_in1 - alu_in2;
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == '0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic rdy(input int w);
      return (w == 1) ? r1_if.req_ready : r0_if.req_ready;
   endfunction
   function automatic logic rvld(input int w);
      return (w == 1) ? r1_if.resp_valid : r0_if.resp_valid;
   endfunction
   function automatic logic [63:0] rres(input int w);
      return (w == 1) ? r1_if.resp_result : r0_if.resp_result;
   endfunction
   function automatic logic rzero(input int w);
      return (w == 1) ? r1_if.resp_zero : r0_if.resp_zero;
   endfunction
   function automatic logic rill(input int w);
      return (w == 1) ? r1_if.resp_illop : r0_if.resp_illop;
   endfunction

   task automatic set_req(input int w, input logic v, input logic [63:0] a,
                          input logic [63:0] b, input logic [3:0] c);
      if (w == 1) begin
         r1_if.req_valid = v; r1_if.op_a = a; r1_if.op_b = b; r1_if.op_ctrl = c;
      end else begin
         r0_if.req_valid = v; r0_if.op_a = a; r0_if.op_b = b; r0_if.op_ctrl = c;
      end
   endtask

   task automatic set_rr(input int w, input logic v);
      if (w == 1) r1_if.resp_ready = v;
      else        r0_if.resp_ready = v;
   endtask

   // Called just after a negedge with the request set; returns #1 into the grant cycle.
   task automatic wait_ready(input int w);
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (rdy(w)) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic do_op(input int w, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] c, input logic [63:0] er,
                        input logic ez, input logic ei);
      @(negedge clk);
      set_req(w, 1'b1, a, b, c);
      set_rr(w, 1'b1);
      wait_ready(w);
      @(negedge clk);
      set_req(w, 1'b0, '0, '0, 4'b0000);
      #1;
      check("exec_resp_valid", {63'd0, rvld(w)}, 64'd0);
      check("exec_busy", {63'd0, busy}, 64'd1);
      @(negedge clk);
      #1;
      check("resp_valid", {63'd0, rvld(w)}, 64'd1);
      check("resp_result", rres(w), er);
      check("resp_zero", {63'd0, rzero(w)}, {63'd0, ez});
      check("resp_illop", {63'd0, rill(w)}, {63'd0, ei});
      check("other_resp_valid", {63'd0, rvld(1 - w)}, 64'd0);
      @(negedge clk);
      #1;
      check("resp_drop", {63'd0, rvld(w)}, 64'd0);
      check("idle_busy", {63'd0, busy}, 64'd0);
   endtask

   initial begin
      int grants[$];
      int exp_grant;

      rst_n = 1'b0;
      set_req(0, 1'b0, '0, '0, 4'b0000);
      set_req(1, 1'b0, '0, '0, 4'b0000);
      set_rr(0, 1'b0);
      set_rr(1, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_alu_in1", alu_in1, 64'd0);
      check("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
      check("rst_r0_resp_valid", {63'd0, r0_if.resp_valid}, 64'd0);
      check("rst_r0_resp_result", r0_if.resp_result, 64'd0);
      rst_n = 1'b1;

      // Reset during EXEC drops the transaction.
      @(negedge clk);
      set_req(0, 1'b1, 64'd5, 64'd7, 4'b0010);
      set_rr(0, 1'b1);
      wait_ready(0);
      @(negedge clk);
      set_req(0, 1'b0, '0, '0, 4'b0000);
      #1;
      check("pre_rst_busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_r0_ready", {63'd0, r0_if.req_ready}, 64'd0);
      check("midrst_r1_ready", {63'd0, r1_if.req_ready}, 64'd0);
      check("midrst_r0_resp_valid", {63'd0, r0_if.resp_valid}, 64'd0);
      check("midrst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check("post_rst_no_resp", {63'd0, r0_if.resp_valid}, 64'd0);
      end

      do_op(0, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 1'b0);
      do_op(1, 64'd9, 64'd9, 4'b0110, 64'd0, 1'b1, 1'b0);
      do_op(1, 64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

      // Continuous contention: r0 ADD 1+2=3, r1 SUB 10-4=6.
      @(negedge clk);
      set_req(0, 1'b1, 64'd1, 64'd2, 4'b0010);
      set_req(1, 1'b1, 64'd10, 64'd4, 4'b0110);
      set_rr(0, 1'b1);
      set_rr(1, 1'b1);
      for (int i = 0; i < 60 && grants.size() < 6; i++) begin
         #1;
         check("one_ready", {63'd0, r0_if.req_ready & r1_if.req_ready}, 64'd0);
         if (r0_if.req_ready) grants.push_back(0);
         if (r1_if.req_ready) grants.push_back(1);
         if (r0_if.resp_valid) check("cont_r0_result", r0_if.resp_result, 64'd3);
         if (r1_if.resp_valid) check("cont_r1_result", r1_if.resp_result, 64'd6);
         @(negedge clk);
      end
      set_req(0, 1'b0, '0, '0, 4'b0000);
      set_req(1, 1'b0, '0, '0, 4'b0000);
      check("grant_count", 64'(grants.size()), 64'd6);
      for (int i = 0; i < grants.size(); i++) begin
         exp_grant = i % 2;
         check("grant_order", 64'(grants[i]), 64'(exp_grant));
      end
      for (int i = 0; i < 10 && busy; i++) @(negedge clk);
      #1;
      check("drain_busy", {63'd0, busy}, 64'd0);

      // Owner stalls its response; the other requester must wait.
      @(negedge clk);
      set_req(0, 1'b1, 64'd2, 64'd3, 4'b0010);
      set_req(1, 1'b1, 64'd7, 64'd1, 4'b0110);
      set_rr(0, 1'b0);
      set_rr(1, 1'b1);
      wait_ready(0);
      check("stall_r1_not_ready", {63'd0, r1_if.req_ready}, 64'd0);
      @(negedge clk);
      set_req(0, 1'b0, '0, '0, 4'b0000);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_resp_valid", {63'd0, r0_if.resp_valid}, 64'd1);
         check("stall_resp_result", r0_if.resp_result, 64'd5);
         check("stall_r1_ready", {63'd0, r1_if.req_ready}, 64'd0);
         @(negedge clk);
      end
      set_rr(0, 1'b1);
      @(negedge clk);
      #1;
      check("stall_resp_drop", {63'd0, r0_if.resp_valid}, 64'd0);
      check("stall_r1_granted", {63'd0, r1_if.req_ready}, 64'd1);
      @(negedge clk);
      set_req(1, 1'b0, '0, '0, 4'b0000);
      @(negedge clk);
      #1;
      check("stall_r1_resp_valid", {63'd0, r1_if.resp_valid}, 64'd1);
      check("stall_r1_result", r1_if.resp_result, 64'd6);
      @(negedge clk);

      do_op(0, 64'd3, 64'd4, 4'b0111, 64'd0, 1'b1, 1'b1);
      do_op(0, 64'hF0, 64'h3C, 4'b0000, 64'h30, 1'b0, 1'b0);
      do_op(1, 64'hF0, 64'h0F, 4'b0001, 64'hFF, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
